rx_timer_ctrl: RTL and testbench
================================

Name: rx_timer_ctrl

Overview:
- Bit-timing controller for the serial receiver datapath; sits between the start-bit detector and the receive shift register/buffer.
- Sequences an internal clock-per-bit counter and a bit counter, both with flex-counter semantics (clear, count_enable, rollover_val, rollover_flag).
- Emits a mid-bit shift strobe for each data bit, samples the stop bit, then issues a one-cycle buffer-load pulse or flags a framing error.

Parameters:
- PERIOD_W, 4, width of bit_period (clocks per serial bit).
- BITS_W, 4, width of data_bits (data bits per frame).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- start_bit_detected  input  1  one-cycle pulse from the start-bit detector
- serial_in  input  1  synchronized serial line, sampled at terminal counts
- bit_period  input  PERIOD_W  clocks per bit (P)
- data_bits  input  BITS_W  data bits per frame (N)
- shift_strobe  output  1  one-cycle pulse: shift serial_in into the data shift register
- load_buffer  output  1  one-cycle pulse: frame valid, load the RX buffer
- frame_done  output  1  one-cycle pulse at end of every frame, good or bad
- framing_error  output  1  sticky flag: the stop bit sampled 0
- parity_error  output  1  sticky flag, see Optional Feature
- busy  output  1  high from frame start until return to IDLE

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE; both counters 0.
  - All outputs 0, including the sticky flags.
  - Reset mid-frame aborts the frame immediately and generates no pulses.
- States: IDLE, RECV, CHECK.
- IDLE:
  - On a clock edge with start_bit_detected=1, latch P and N and go to RECV.
  - At that same edge: clk_cnt=0, bit_cnt=0, busy=1, framing_error=0, parity_error=0.
- Config clamps at latch time:
  - P<2 is treated as 2.
  - N=0 is treated as 1.
  - Changes to bit_period or data_bits while busy are ignored.
- RECV timing:
  - clk_cnt increments every cycle.
  - Terminal count T is P+floor(P/2) for the first bit (centres on data bit 0), then P for every later bit.
  - In the cycle where clk_cnt==T, the terminal event fires. At that edge clk_cnt wraps to 1 and bit_cnt increments.
  - Terminal events therefore occur 1.5P, 2.5P, 3.5P, ... cycles after the entry edge.
- Terminal events 1..N:
  - shift_strobe=1 for that cycle (combinational on state and counters, one cycle wide).
- Terminal event N+1 (stop bit):
  - No shift_strobe.
  - Register serial_in as stop_sample and go to CHECK.
- CHECK (exactly 1 cycle):
  - frame_done=1.
  - If stop_sample=1: load_buffer=1.
  - Else: load_buffer=0, and framing_error is set at the exit edge.
  - Next state IDLE; busy drops at the same exit edge.
- Sticky flags: hold until the next accepted start_bit_detected or reset.
- start_bit_detected while busy (RECV or CHECK) is ignored; no queuing.
- A start_bit_detected on the cycle IDLE is re-entered (the edge after CHECK) is accepted normally. Back-to-back frames therefore have a minimum 1 IDLE cycle between them.
- Pulse exclusivity: shift_strobe, load_buffer and frame_done are never high in the same cycle.

Optional Feature:
- Macro: RX_PARITY_CHECK_EN.
- Defined:
  - One extra bit period is inserted between data and stop: terminal event N+1 samples the parity bit and N+2 samples the stop bit.
  - Even parity is accumulated over the N sampled data bits plus the parity bit.
  - On a mismatch, parity_error is set at the CHECK exit edge and load_buffer is suppressed.
  - frame_done still pulses.
- Undefined:
  - No parity period; frame timing is as in Behaviour.
  - parity_error is tied 0.

Test Plan:
- Reset: n_rst=0 mid-RECV with P=4, N=8 -> all outputs 0 immediately; after release, busy stays 0 until the next start pulse.
- Nominal frame, P=4, N=8, serial_in=1 at stop:
  - shift_strobe on cycles 6,10,...,34 after the entry edge (8 pulses).
  - Stop sampled at cycle 38.
  - load_buffer=1 and frame_done=1 in cycle 39; busy=0 from cycle 40.
- Framing error: same frame with serial_in=0 at cycle 38 -> load_buffer stays 0, frame_done pulses, framing_error=1 and holds until the next start_bit_detected clears it.
- Clamps: P=1, N=0 -> behaves as P=2, N=1: one shift_strobe at cycle 3, stop sampled at cycle 5.
- Ignore/config hold: pulse start_bit_detected and change bit_period to 9 while in RECV -> no restart, timing stays at the latched P; a start pulse on the first IDLE cycle after CHECK starts a new frame.
- RX_PARITY_CHECK_EN, P=4, N=8, data with odd ones count and parity bit 0 -> parity_error=1, no load_buffer, frame_done at cycle 43.

Source files
------------

// File: rtl/rx_timer_ctrl.sv
// Bit-timing controller for the serial receiver: mid-bit shift strobes, stop-bit check, buffer load.
// Optional even-parity period and check enabled by defining RX_PARITY_CHECK_EN.
module rx_timer_ctrl #(
   parameter int unsigned PERIOD_W = 4,
   parameter int unsigned BITS_W   = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start_bit_detected,
   input  logic                serial_in,
   input  logic [PERIOD_W-1:0] bit_period,
   input  logic [BITS_W-1:0]   data_bits,
   output logic                shift_strobe,
   output logic                load_buffer,
   output logic                frame_done,
   output logic                framing_error,
   output logic                parity_error,
   output logic                busy
);

   localparam int unsigned CNT_W  = PERIOD_W + 1;
   localparam int unsigned BCNT_W = BITS_W + 1;

   typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [BITS_W-1:0]   nbits_q, nbits_d;
   logic                stop_q, stop_d;
   logic                ferr_q, ferr_d;
`ifdef RX_PARITY_CHECK_EN
   logic                par_q, par_d;
   logic                perr_q, perr_d;
`endif

   logic [CNT_W-1:0]    term_val;
   logic [BCNT_W-1:0]   nbits_ext;
   logic                data_phase;

   // First bit waits an extra half period so sampling lands mid-bit.
   assign term_val   = (bit_cnt_q == '0) ? ({1'b0, period_q} + CNT_W'(period_q >> 1))
                                         : {1'b0, period_q};
   assign nbits_ext  = {1'b0, nbits_q};
   assign data_phase = bit_cnt_q < nbits_ext;

   always_comb begin
      state_d      = state_q;
      clk_cnt_d    = clk_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      period_d     = period_q;
      nbits_d      = nbits_q;
      stop_d       = stop_q;
      ferr_d       = ferr_q;
`ifdef RX_PARITY_CHECK_EN
      par_d        = par_q;
      perr_d       = perr_q;
`endif
      shift_strobe = 1'b0;
      load_buffer  = 1'b0;
      frame_done   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_bit_detected) begin
               period_d  = (bit_period < PERIOD_W'(2)) ? PERIOD_W'(2) : bit_period;
               nbits_d   = (data_bits == '0) ? BITS_W'(1) : data_bits;
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               ferr_d    = 1'b0;
`ifdef RX_PARITY_CHECK_EN
               par_d     = 1'b0;
               perr_d    = 1'b0;
`endif
               state_d   = StRecv;
            end
         end
         StRecv: begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
            if (clk_cnt_q == term_val) begin
               clk_cnt_d = CNT_W'(1);
               bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               if (data_phase) begin
                  shift_strobe = 1'b1;
`ifdef RX_PARITY_CHECK_EN
                  par_d = par_q ^ serial_in;
               end else if (bit_cnt_q == nbits_ext) begin
                  par_d = par_q ^ serial_in;
`endif
               end else begin
                  stop_d  = serial_in;
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            frame_done = 1'b1;
`ifdef RX_PARITY_CHECK_EN
            load_buffer = stop_q & ~par_q;
            if (par_q) perr_d = 1'b1;
`else
            load_buffer = stop_q;
`endif
            if (!stop_q) ferr_d = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= StIdle;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         period_q  <= '0;
         nbits_q   <= '0;
         stop_q    <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         period_q  <= period_d;
         nbits_q   <= nbits_d;
         stop_q    <= stop_d;
         ferr_q    <= ferr_d;
`ifdef RX_PARITY_CHECK_EN
         par_q     <= par_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign busy          = (state_q != StIdle);
   assign framing_error = ferr_q;
`ifdef RX_PARITY_CHECK_EN
   assign parity_error  = perr_q;
`else
   assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_timer_ctrl.sv
// Table-driven bench for rx_timer_ctrl: frame timing, clamps, ignored starts, sticky flags,
// back-to-back frames and asynchronous reset.
module tb_rx_timer_ctrl;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       start_bit_detected = 1'b0;
   logic       serial_in = 1'b1;
   logic [3:0] bit_period = 4'd4;
   logic [3:0] data_bits = 4'd8;
   logic       shift_strobe, load_buffer, frame_done, framing_error, parity_error, busy;

   int n_tests = 0;
   int n_fail  = 0;

   rx_timer_ctrl #(.PERIOD_W(4), .BITS_W(4)) dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .start_bit_detected (start_bit_detected),
      .serial_in          (serial_in),
      .bit_period         (bit_period),
      .data_bits          (data_bits),
      .shift_strobe       (shift_strobe),
      .load_buffer        (load_buffer),
      .frame_done         (frame_done),
      .framing_error      (framing_error),
      .parity_error       (parity_error),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   // Cycle numbers count from the accepting edge (cycle 0 follows it).
   typedef struct {
      int p; int n; bit stop; int glitch; int z0; int z1;
      int first; int cnt; int last; int done; bit load; bit ferr; bit perr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int p, int n, bit stop, int glitch, int z0, int z1, int first,
                               int cnt, int last, int done, bit load, bit ferr, bit perr);
      vec_t v;
      v.p = p; v.n = n; v.stop = stop; v.glitch = glitch; v.z0 = z0; v.z1 = z1;
      v.first = first; v.cnt = cnt; v.last = last; v.done = done;
      v.load = load; v.ferr = ferr; v.perr = perr;
      return v;
   endfunction

   task automatic check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Caller is at a negedge; the frame is accepted on the next posedge.
   task automatic run_frame(int idx, vec_t v);
      int  first = -1, cnt = 0, last = -1, done = -1, load_cyc = -1, drop = -1, multi = 0;
      bit  finished = 0;
      int  stop_cyc;
      stop_cyc = v.done - 1;
      start_bit_detected = 1'b1;
      bit_period = 4'(v.p);
      data_bits  = 4'(v.n);
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         start_bit_detected = (cyc == v.glitch);
         if (cyc == v.glitch) bit_period = 4'd9;
         if (cyc == stop_cyc)                 serial_in = v.stop;
         else if (cyc == v.z0 || cyc == v.z1) serial_in = 1'b0;
         else                                 serial_in = 1'b1;
         @(negedge clk);
         if (cyc == 0) begin
            check($sformatf("v%0d ferr_cleared", idx), framing_error, 0);
            check($sformatf("v%0d busy_at_entry", idx), busy, 1);
         end
         if (shift_strobe) begin
            if (first < 0) first = cyc;
            last = cyc;
            cnt++;
         end
         if (frame_done)  done = cyc;
         if (load_buffer) load_cyc = cyc;
         if (int'(shift_strobe) + int'(frame_done) + int'(load_buffer) > 1 &&
             !(frame_done && load_buffer)) multi++;
         if (shift_strobe && (frame_done || load_buffer)) multi++;
         if (!busy) begin
            drop = cyc;
            finished = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      start_bit_detected = 1'b0;
      serial_in = 1'b1;
      check($sformatf("v%0d completed", idx), finished, 1);
      check($sformatf("v%0d first_strobe", idx), first, v.first);
      check($sformatf("v%0d strobe_count", idx), cnt, v.cnt);
      check($sformatf("v%0d last_strobe", idx), last, v.last);
      check($sformatf("v%0d frame_done_cycle", idx), done, v.done);
      check($sformatf("v%0d load_cycle", idx), load_cyc, v.load ? v.done : -1);
      check($sformatf("v%0d busy_drop", idx), drop, v.done + 1);
      check($sformatf("v%0d framing_error", idx), framing_error, v.ferr);
      check($sformatf("v%0d parity_error", idx), parity_error, v.perr);
      check($sformatf("v%0d strobe_exclusive", idx), multi, 0);
   endtask

   initial begin
      int bad;
`ifndef RX_PARITY_CHECK_EN
      //              p  n  st glt z0  z1 first cnt last done load ferr perr
      vecs.push_back(mk(4, 8, 1, 10, -1, -1, 6, 8, 34, 39, 1, 0, 0));
      vecs.push_back(mk(4, 8, 0, -1, -1, -1, 6, 8, 34, 39, 0, 1, 0));
      vecs.push_back(mk(1, 0, 1, -1, -1, -1, 3, 1, 3, 6, 1, 0, 0));
      vecs.push_back(mk(2, 3, 1, 4, -1, -1, 3, 3, 7, 10, 1, 0, 0));
      vecs.push_back(mk(3, 1, 1, -1, -1, -1, 4, 1, 4, 8, 1, 0, 0));
      vecs.push_back(mk(5, 2, 0, -1, -1, -1, 7, 2, 12, 18, 0, 1, 0));
`else
      // Parity bit sampled at 38, stop at 42.
      vecs.push_back(mk(4, 8, 1, -1, 6, 38, 6, 8, 34, 43, 0, 0, 1));
      vecs.push_back(mk(4, 8, 1, -1, -1, 38, 6, 8, 34, 43, 1, 0, 0));
      vecs.push_back(mk(4, 8, 0, 10, 6, 38, 6, 8, 34, 43, 0, 1, 1));
`endif

      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_pulses", {shift_strobe, load_buffer, frame_done}, 0);
      check("reset_flags", {framing_error, parity_error}, 0);
      n_rst = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_frame(i, vecs[i]);

      // Last frame ends in error; the flag must hold through idle cycles.
      repeat (5) @(negedge clk);
      check("ferr_sticky_idle", framing_error, 1);
      check("idle_not_busy", busy, 0);
      n_rst = 1'b0;
      #1;
      check("reset_clears_ferr", framing_error, 0);
      @(negedge clk);
      n_rst = 1'b1;

      // Reset mid-RECV, in a cycle that carries a shift strobe.
      @(negedge clk);
      start_bit_detected = 1'b1;
      bit_period = 4'd4;
      data_bits  = 4'd8;
      @(posedge clk); #1;
      start_bit_detected = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      check("pre_reset_strobe", shift_strobe, 1);
      n_rst = 1'b0;
      #1;
      check("midframe_reset_busy", busy, 0);
      check("midframe_reset_pulses", {shift_strobe, load_buffer, frame_done}, 0);
      check("midframe_reset_flags", {framing_error, parity_error}, 0);
      @(negedge clk);
      n_rst = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (busy || shift_strobe || load_buffer || frame_done) bad++;
      end
      check("post_reset_quiet", bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
